// File: rtl/xhost_bridge_pkg.sv
// Shared widths, FSM state encodings and helpers for the xhost_bridge host bus initiator.
package xhost_bridge_pkg;

   localparam int XHOST_ADDR_W = 32;
   localparam int XHOST_DATA_W = 32;
   localparam int XHOST_STRIDE = 4;
   localparam int XHOST_CNT_W  = 3;

   typedef logic [1:0] xhost_state_t;

   localparam logic [1:0] XHOST_IDLE   = 2'd0;
   localparam logic [1:0] XHOST_ACCESS = 2'd1;
   localparam logic [1:0] XHOST_WAIT   = 2'd2;
   localparam logic [1:0] XHOST_RESP   = 2'd3;

   // Counter preload for a read latency; ACCESS already covers the first cycle.
   function automatic logic [XHOST_CNT_W-1:0] xhost_lat_load(input int rd_lat);
      return XHOST_CNT_W'(rd_lat - 1);
   endfunction

endpackage

// File: rtl/xhost_lat_cnt.sv
// Read-latency down-counter: preloaded on entry to the wait phase, done while it sits at one.
module xhost_lat_cnt
   import xhost_bridge_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [XHOST_CNT_W-1:0] load_val,
   output logic                   done
);

   logic [XHOST_CNT_W-1:0] cnt_r;

   // Load wins; otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {XHOST_CNT_W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != {XHOST_CNT_W{1'b0}}) begin
         cnt_r <= cnt_r - XHOST_CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = (cnt_r == XHOST_CNT_W'(1));

endmodule

// File: rtl/xhost_bridge.sv
// Host command to peripheral-bus bridge: one bus transaction and one response per command word.
// Define XHOST_BURST_EN to add cmd_len and multi-word bursts at a 4-byte stride.
module xhost_bridge
   import xhost_bridge_pkg::*;
#(
   parameter int ADDR_W = XHOST_ADDR_W,
   parameter int DATA_W = XHOST_DATA_W,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
`ifdef XHOST_BURST_EN
   input  logic [7:0]        cmd_len,
`endif
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] addr,
   output logic              sel,
   output logic              we,
   output logic [DATA_W-1:0] data_to_wr,
   input  logic [DATA_W-1:0] data_to_rd,
   input  logic              trap_sel
);

   localparam logic [XHOST_CNT_W-1:0] LAT_LOAD = xhost_lat_load(RD_LAT);

   xhost_state_t state_r;
   logic         err_r;
   logic         we_cmd_r;
   logic         lat_load_s;
   logic         lat_done_s;
`ifdef XHOST_BURST_EN
   logic [7:0]   len_r;
`endif

   // The bus we is dropped after ACCESS, so the command direction is kept separately.
   assign lat_load_s = (state_r == XHOST_ACCESS) && !we_cmd_r;

   xhost_lat_cnt u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (lat_load_s),
      .load_val (LAT_LOAD),
      .done     (lat_done_s)
   );

   // Bridge FSM; every output is driven straight from a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= XHOST_IDLE;
         cmd_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= {DATA_W{1'b0}};
         rsp_err    <= 1'b0;
         addr       <= {ADDR_W{1'b0}};
         sel        <= 1'b0;
         we         <= 1'b0;
         data_to_wr <= {DATA_W{1'b0}};
         err_r      <= 1'b0;
         we_cmd_r   <= 1'b0;
`ifdef XHOST_BURST_EN
         len_r      <= 8'd0;
`endif
      end else begin
         case (state_r)
            XHOST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  addr       <= cmd_addr;
                  we         <= cmd_we;
                  we_cmd_r   <= cmd_we;
                  data_to_wr <= cmd_wdata;
                  sel        <= 1'b1;
                  cmd_ready  <= 1'b0;
                  state_r    <= XHOST_ACCESS;
`ifdef XHOST_BURST_EN
                  len_r      <= cmd_len;
`endif
               end else begin
                  cmd_ready  <= 1'b1;
               end
            end
            XHOST_ACCESS: begin
               sel   <= 1'b0;
               we    <= 1'b0;
               err_r <= trap_sel;
               if (we_cmd_r) begin
                  rsp_rdata <= {DATA_W{1'b0}};
                  rsp_err   <= trap_sel;
                  rsp_valid <= 1'b1;
                  state_r   <= XHOST_RESP;
               end else if (RD_LAT == 1) begin
                  rsp_rdata <= data_to_rd;
                  rsp_err   <= trap_sel;
                  rsp_valid <= 1'b1;
                  state_r   <= XHOST_RESP;
               end else begin
                  state_r   <= XHOST_WAIT;
               end
            end
            XHOST_WAIT: begin
               if (lat_done_s) begin
                  rsp_rdata <= data_to_rd;
                  rsp_err   <= err_r;
                  rsp_valid <= 1'b1;
                  state_r   <= XHOST_RESP;
               end else begin
                  state_r   <= XHOST_WAIT;
               end
            end
            XHOST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
`ifdef XHOST_BURST_EN
                  // Further words reuse the held write data and restart ACCESS right away.
                  if (len_r != 8'd0) begin
                     len_r   <= len_r - 8'd1;
                     addr    <= addr + ADDR_W'(XHOST_STRIDE);
                     we      <= we_cmd_r;
                     sel     <= 1'b1;
                     state_r <= XHOST_ACCESS;
                  end else begin
                     cmd_ready <= 1'b1;
                     state_r   <= XHOST_IDLE;
                  end
`else
                  cmd_ready <= 1'b1;
                  state_r   <= XHOST_IDLE;
`endif
               end else begin
                  state_r   <= XHOST_RESP;
               end
            end
            default: begin
               state_r <= XHOST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xhost_bridge.sv
// Scoreboard bench for xhost_bridge: instance a has RD_LAT=1, instance b has RD_LAT=3.
module tb_xhost_bridge;

   localparam logic [31:0] MEM_BASE  = 32'h1000_0000;
   localparam logic [31:0] LED0_BASE = 32'h2000_0000;
   localparam logic [31:0] SW_BASE   = 32'h2000_0100;
   localparam logic [31:0] BAD_ADDR  = 32'h7000_0040;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } rsp_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } bus_exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_cmd_valid, a_cmd_ready, a_cmd_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic        a_sel, a_we, a_trap_sel;
   logic [31:0] a_cmd_addr, a_cmd_wdata, a_rsp_rdata, a_addr, a_data_to_wr, a_data_to_rd;
   logic        b_cmd_valid, b_cmd_ready, b_cmd_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic        b_sel, b_we, b_trap_sel;
   logic [31:0] b_cmd_addr, b_cmd_wdata, b_rsp_rdata, b_addr, b_data_to_wr, b_data_to_rd;
   logic [2:0]  b_cnt;
`ifdef XHOST_BURST_EN
   logic [7:0]  a_cmd_len, b_cmd_len;
`endif

   xhost_bridge #(.RD_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_we(a_cmd_we), .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
`ifdef XHOST_BURST_EN
      .cmd_len(a_cmd_len),
`endif
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
      .rsp_err(a_rsp_err), .addr(a_addr), .sel(a_sel), .we(a_we),
      .data_to_wr(a_data_to_wr), .data_to_rd(a_data_to_rd), .trap_sel(a_trap_sel)
   );

   xhost_bridge #(.RD_LAT(3)) dut_b (
      .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_we(b_cmd_we), .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
`ifdef XHOST_BURST_EN
      .cmd_len(b_cmd_len),
`endif
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
      .rsp_err(b_rsp_err), .addr(b_addr), .sel(b_sel), .we(b_we),
      .data_to_wr(b_data_to_wr), .data_to_rd(b_data_to_rd), .trap_sel(b_trap_sel)
   );

   // Decoder model for a: switch register, address-tagged memory, trap above 0x7000_0000.
   always_comb begin
      a_trap_sel = a_sel && (a_addr[31:28] == 4'h7);
      if (a_addr == SW_BASE) a_data_to_rd = 32'h0000_003C;
      else if (a_addr[31:28] == 4'h1) a_data_to_rd = 32'hC0DE_0000 | {16'h0000, a_addr[15:0]};
      else a_data_to_rd = 32'h0000_0000;
   end

   // Slow memory for b: data valid only in the 3rd cycle counting the sel cycle as the 1st.
   always @(posedge clk) begin
      if (rst) b_cnt <= 3'd0;
      else if (b_sel) b_cnt <= 3'd2;
      else if (b_cnt != 3'd0 && b_cnt != 3'd7) b_cnt <= b_cnt + 3'd1;
      else b_cnt <= 3'd0;
   end
   assign b_data_to_rd = (b_cnt == 3'd3) ? 32'hDEAD_BEEF : 32'h0000_0000;
   assign b_trap_sel   = 1'b0;

   rsp_exp_t rq_a[$], rq_b[$];
   bus_exp_t bq_a[$], bq_b[$];
   int n_chk = 0, n_fail = 0, ncyc = 0;
   int acc[2], seen[2], sel_prev[2];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s actual=event expected=none (t=%0t)", nm, $time);
   endtask

   function automatic int rsp_len(input int id);
      return (id == 0) ? rq_a.size() : rq_b.size();
   endfunction

   function automatic int bus_len(input int id);
      return (id == 0) ? bq_a.size() : bq_b.size();
   endfunction

   task automatic push(input int id, input logic [31:0] rd, input logic er, input int lat,
                       input logic [31:0] ad, input logic w, input logic [31:0] wd);
      rsp_exp_t e;
      bus_exp_t b;
      e.rdata = rd; e.err = er; e.lat = lat;
      b.addr = ad; b.we = w; b.wdata = wd;
      if (id == 0) begin rq_a.push_back(e); bq_a.push_back(b); end
      else begin rq_b.push_back(e); bq_b.push_back(b); end
   endtask

   // Monitor: checks each sel pulse against the bus queue and each response against the response queue.
   task automatic mon(input int id, input logic cv, input logic cr, input logic rv, input logic rr,
                      input logic [31:0] rd, input logic er, input logic sl,
                      input logic [31:0] ad, input logic w, input logic [31:0] wd);
      rsp_exp_t e;
      bus_exp_t b;
      if (rst) begin
         seen[id] = 0;
         sel_prev[id] = 0;
      end else begin
         if (cv && cr) acc[id] = ncyc;
         if (sel_prev[id] != 0) check($sformatf("sel_width%0d", id), {63'd0, sl}, 64'd0);
         if (sl && sel_prev[id] == 0) begin
            if (bus_len(id) == 0) fail_now($sformatf("bus_unexpected%0d", id));
            else begin
               b = (id == 0) ? bq_a.pop_front() : bq_b.pop_front();
               check($sformatf("bus_addr%0d", id), {32'd0, ad}, {32'd0, b.addr});
               check($sformatf("bus_we%0d", id), {63'd0, w}, {63'd0, b.we});
               if (b.we) check($sformatf("bus_wdata%0d", id), {32'd0, wd}, {32'd0, b.wdata});
            end
         end
         sel_prev[id] = sl ? 1 : 0;
         if (rv && seen[id] == 0) begin
            seen[id] = 1;
            if (rsp_len(id) == 0) fail_now($sformatf("rsp_unexpected%0d", id));
            else begin
               e = (id == 0) ? rq_a[0] : rq_b[0];
               if (e.lat > 0) check($sformatf("rsp_lat%0d", id), 64'(ncyc - acc[id]), 64'(e.lat));
            end
         end
         if (rv && rr && rsp_len(id) != 0) begin
            e = (id == 0) ? rq_a.pop_front() : rq_b.pop_front();
            check($sformatf("rsp_rdata%0d", id), {32'd0, rd}, {32'd0, e.rdata});
            check($sformatf("rsp_err%0d", id), {63'd0, er}, {63'd0, e.err});
            seen[id] = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_ready, a_rsp_rdata, a_rsp_err,
          a_sel, a_addr, a_we, a_data_to_wr);
      mon(1, b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_rsp_rdata, b_rsp_err,
          b_sel, b_addr, b_we, b_data_to_wr);
      ncyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds a command until accepted (bounded), then drops cmd_valid after the accept edge.
   task automatic issue(input int id, input logic w, input logic [31:0] ad, input logic [31:0] wd);
      int n = 0;
      if (id == 0) begin a_cmd_valid = 1'b1; a_cmd_we = w; a_cmd_addr = ad; a_cmd_wdata = wd; end
      else begin b_cmd_valid = 1'b1; b_cmd_we = w; b_cmd_addr = ad; b_cmd_wdata = wd; end
      while (((id == 0) ? a_cmd_ready : b_cmd_ready) !== 1'b1 && n < 50) begin step(); n++; end
      if (n >= 50) fail_now($sformatf("accept_timeout%0d", id));
      step();
      a_cmd_valid = 1'b0;
      b_cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int id);
      int n = 0;
      while ((rsp_len(id) != 0 || ((id == 0) ? a_cmd_ready : b_cmd_ready) !== 1'b1) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) fail_now($sformatf("done_timeout%0d", id));
   endtask

   initial begin
      rst = 1'b1;
      a_cmd_valid = 1'b0; a_cmd_we = 1'b0; a_cmd_addr = 32'd0; a_cmd_wdata = 32'd0; a_rsp_ready = 1'b1;
      b_cmd_valid = 1'b0; b_cmd_we = 1'b0; b_cmd_addr = 32'd0; b_cmd_wdata = 32'd0; b_rsp_ready = 1'b1;
`ifdef XHOST_BURST_EN
      a_cmd_len = 8'd0; b_cmd_len = 8'd0;
`endif
      repeat (3) step();
      check("rst_ctrl_a", {59'd0, a_cmd_ready, a_rsp_valid, a_rsp_err, a_sel, a_we}, 64'd0);
      check("rst_addr_a", {32'd0, a_addr}, 64'd0);
      check("rst_wdata_a", {32'd0, a_data_to_wr}, 64'd0);
      check("rst_rdata_a", {32'd0, a_rsp_rdata}, 64'd0);
      check("rst_ctrl_b", {59'd0, b_cmd_ready, b_rsp_valid, b_rsp_err, b_sel, b_we}, 64'd0);
      rst = 1'b0;
      step();
      check("ready_after_rst", {62'd0, a_cmd_ready, b_cmd_ready}, 64'd3);

      // Writes and reads on the RD_LAT=1 instance, including trap hits.
      push(0, 32'h0, 1'b0, 2, LED0_BASE, 1'b1, 32'h0000_00A5);
      issue(0, 1'b1, LED0_BASE, 32'h0000_00A5);
      wait_done(0);
      push(0, 32'h0000_003C, 1'b0, 2, SW_BASE, 1'b0, 32'h0);
      issue(0, 1'b0, SW_BASE, 32'h0);
      wait_done(0);
      push(0, 32'h0, 1'b1, 2, BAD_ADDR, 1'b0, 32'h0);
      issue(0, 1'b0, BAD_ADDR, 32'h0);
      wait_done(0);
      push(0, 32'hC0DE_0000, 1'b0, 2, MEM_BASE, 1'b0, 32'h0);
      issue(0, 1'b0, MEM_BASE, 32'h0);
      wait_done(0);
      push(0, 32'h0, 1'b1, 2, BAD_ADDR, 1'b1, 32'h0000_0055);
      issue(0, 1'b1, BAD_ADDR, 32'h0000_0055);
      wait_done(0);

      // RD_LAT=3 instance: slow read and a write.
      push(1, 32'hDEAD_BEEF, 1'b0, 4, MEM_BASE, 1'b0, 32'h0);
      issue(1, 1'b0, MEM_BASE, 32'h0);
      wait_done(1);
      push(1, 32'h0, 1'b0, 2, MEM_BASE + 32'h10, 1'b1, 32'h1234_5678);
      issue(1, 1'b1, MEM_BASE + 32'h10, 32'h1234_5678);
      wait_done(1);

      // Host backpressure: the response must hold steady.
      a_rsp_ready = 1'b0;
      push(0, 32'h0000_003C, 1'b0, 2, SW_BASE, 1'b0, 32'h0);
      issue(0, 1'b0, SW_BASE, 32'h0);
      for (int i = 0; i < 20 && a_rsp_valid !== 1'b1; i++) step();
      for (int i = 0; i < 10; i++) begin
         check("bp_ctrl", {61'd0, a_rsp_valid, a_cmd_ready, a_rsp_err}, 64'd4);
         check("bp_rdata", {32'd0, a_rsp_rdata}, 64'h3C);
         step();
      end
      a_rsp_ready = 1'b1;
      wait_done(0);

      // Reset during WAIT on b: the response is discarded.
      bq_b.push_back('{addr: MEM_BASE + 32'h20, we: 1'b0, wdata: 32'h0});
      issue(1, 1'b0, MEM_BASE + 32'h20, 32'h0);
      step();
      check("wait_hold", {31'd0, b_sel, b_addr}, {32'd0, MEM_BASE + 32'h20});
      rst = 1'b1;
      step();
      check("midrst_ctrl_b", {59'd0, b_cmd_ready, b_rsp_valid, b_rsp_err, b_sel, b_we}, 64'd0);
      check("midrst_addr_b", {32'd0, b_addr}, 64'd0);
      check("midrst_data_b", {b_data_to_wr, b_rsp_rdata}, 64'd0);
      rst = 1'b0;
      step();
      check("midrst_ready_b", {63'd0, b_cmd_ready}, 64'd1);
      repeat (6) step();
      check("midrst_no_rsp", {63'd0, b_rsp_valid}, 64'd0);

`ifdef XHOST_BURST_EN
      // Three-word read burst, then a two-word write burst wrapping past the top address.
      push(0, 32'hC0DE_0000, 1'b0, 2, MEM_BASE, 1'b0, 32'h0);
      push(0, 32'hC0DE_0004, 1'b0, -1, MEM_BASE + 32'h4, 1'b0, 32'h0);
      push(0, 32'hC0DE_0008, 1'b0, -1, MEM_BASE + 32'h8, 1'b0, 32'h0);
      a_cmd_len = 8'd2;
      issue(0, 1'b0, MEM_BASE, 32'h0);
      for (int i = 0; i < 40 && rq_a.size() != 0; i++) begin
         check("burst_ready_low", {63'd0, a_cmd_ready}, 64'd0);
         step();
      end
      wait_done(0);
      push(0, 32'h0, 1'b0, 2, 32'hFFFF_FFFC, 1'b1, 32'h0000_00C3);
      push(0, 32'h0, 1'b0, -1, 32'h0000_0000, 1'b1, 32'h0000_00C3);
      a_cmd_len = 8'd1;
      issue(0, 1'b1, 32'hFFFF_FFFC, 32'h0000_00C3);
      a_cmd_len = 8'd0;
      wait_done(0);
`endif

      repeat (4) step();
      check("queues_empty", 64'(rq_a.size() + rq_b.size() + bq_a.size() + bq_b.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
